// File: rtl/clk_sync_pulse_tracker.sv
// rtl/clk_sync_pulse_tracker.sv - sync-pulse timing core: master pulse generator or
// slave tracker with acceptance window, offset measurement, miss counting and holdover.
module clk_sync_pulse_tracker #(
  parameter int CNT_W     = 64,
  parameter int PULSE_LEN = 4,
  parameter int MISS_W    = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic              cfg_master_mode_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [7:0]        cfg_window_i,
  input  logic [3:0]        cfg_max_miss_i,
  input  logic              tick_en_i,
  input  logic              sync_pulse_i,
  input  logic              clr_stats_i,
  output logic              sync_pulse_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  curr_tick_o,
  output logic [CNT_W-1:0]  nb_sync_o,
  output logic [MISS_W-1:0] nb_miss_o,
  output logic [MISS_W-1:0] nb_reject_o,
  output logic [15:0]       last_offset_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2,
    ST_MASTER   = 2'd3
  } state_t;

  localparam int SW = $clog2(PULSE_LEN + 1);
  localparam logic [SW-1:0] STRETCH_LEN = SW'(PULSE_LEN);
  localparam logic signed [CNT_W:0] OFF_MAX = (CNT_W+1)'(32767);
  localparam logic signed [CNT_W:0] OFF_MIN = ~OFF_MAX;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, period, last_tick, half, win, we, late_lo;
  logic [SW-1:0]    stretch;
  logic [3:0]       miss_run, max_eff;
  logic             sync_q, seen, rise, at_end, in_early, in_late;
  logic             realign, lock, accept, reject, check, miss, issue, wrap, use_late;
  logic             master_wrap;
  logic signed [CNT_W:0] off_full;
  logic [15:0]      off_sat;

  assign period    = (cfg_period_i < CNT_W'(2)) ? CNT_W'(2) : cfg_period_i;
  assign last_tick = period - CNT_W'(1);
  assign half      = last_tick >> 1;
  assign win       = CNT_W'(cfg_window_i);
  assign we        = (win < half) ? win : half;
  assign late_lo   = period - we;
  assign max_eff   = (cfg_max_miss_i == 4'd0) ? 4'd1 : cfg_max_miss_i;
  assign at_end    = (cnt >= last_tick);
  assign rise      = sync_pulse_i & ~sync_q;
  assign in_early  = (cnt <= we);
  assign in_late   = (cnt >= late_lo);

  always_comb begin
    state_n  = state;
    realign  = 1'b0;
    lock     = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    check    = 1'b0;
    miss     = 1'b0;
    issue    = 1'b0;
    use_late = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (rise) begin
          lock    = 1'b1;
          state_n = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (in_early) begin
            accept = 1'b1;
          end else if (in_late) begin
            accept   = 1'b1;
            use_late = 1'b1;
            issue    = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        // An accept in the check cycle stands in for the check itself.
        if (tick_en_i && (cnt == we) && !accept) begin
          check = 1'b1;
          if (!seen) begin
            miss = 1'b1;
            if (({1'b0, miss_run} + 5'd1) >= {1'b0, max_eff}) state_n = ST_HOLDOVER;
          end
        end
      end
      ST_HOLDOVER: begin
        if (rise) begin
          accept   = 1'b1;
          use_late = in_late && !in_early;
          issue    = 1'b1;
          state_n  = ST_LOCKED;
        end
      end
      default: ;
    endcase
    realign     = lock | accept;
    wrap        = tick_en_i && at_end && !realign;
    master_wrap = wrap && (state == ST_MASTER);
    if (wrap && (state != ST_UNLOCKED)) issue = 1'b1;
    if (cfg_master_mode_i) state_n = ST_MASTER;
    else if (state == ST_MASTER) state_n = ST_UNLOCKED;
  end

  always_comb begin
    off_full = use_late ? ($signed({1'b0, cnt}) - $signed({1'b0, period}))
                        : $signed({1'b0, cnt});
    if (off_full > OFF_MAX)      off_sat = 16'h7fff;
    else if (off_full < OFF_MIN) off_sat = 16'h8000;
    else                         off_sat = off_full[15:0];
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state <= ST_UNLOCKED;
    else               state <= state_n;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      sync_q        <= 1'b0;
      cnt           <= '0;
      stretch       <= '0;
      seen          <= 1'b0;
      miss_run      <= '0;
      nb_sync_o     <= '0;
      nb_miss_o     <= '0;
      nb_reject_o   <= '0;
      last_offset_o <= '0;
    end else begin
      sync_q <= sync_pulse_i;
      if (realign)        cnt <= '0;
      else if (tick_en_i) cnt <= at_end ? '0 : cnt + CNT_W'(1);
      if (issue)                 stretch <= STRETCH_LEN;
      else if (stretch != '0)    stretch <= stretch - SW'(1);
      if (realign)    seen <= 1'b1;
      else if (check) seen <= 1'b0;
      if (realign)   miss_run <= '0;
      else if (miss) miss_run <= miss_run + 4'd1;
      if (clr_stats_i) begin
        nb_sync_o     <= '0;
        nb_miss_o     <= '0;
        nb_reject_o   <= '0;
        last_offset_o <= '0;
      end else begin
        if (realign || master_wrap) nb_sync_o   <= nb_sync_o + CNT_W'(1);
        if (miss)                   nb_miss_o   <= nb_miss_o + MISS_W'(1);
        if (reject)                 nb_reject_o <= nb_reject_o + MISS_W'(1);
        if (accept)                 last_offset_o <= off_sat;
      end
    end
  end

  assign sync_pulse_o = (stretch != '0);
  assign state_o      = state;
  assign curr_tick_o  = cnt;

endmodule

// File: tb/tb_clk_sync_pulse_tracker.sv
// tb/tb_clk_sync_pulse_tracker.sv - scenario bench for clk_sync_pulse_tracker; expected
// pulse start cycles are queued with the stimulus and matched against observed pulses.
module tb_clk_sync_pulse_tracker;
  localparam int CNT_W = 64;
  localparam int PULSE_LEN = 4;
  localparam int MISS_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              master = 1'b0;
  logic [CNT_W-1:0]  period = 64'd10;
  logic [7:0]        window = 8'd2;
  logic [3:0]        max_miss = 4'd3;
  logic              tick_en = 1'b1;
  logic              sync_in = 1'b0;
  logic              clr = 1'b0;
  logic              sync_out;
  logic [1:0]        state;
  logic [CNT_W-1:0]  curr_tick, nb_sync;
  logic [MISS_W-1:0] nb_miss, nb_reject;
  logic [15:0]       last_offset;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs_q[$];
  int len_q[$];
  int exp_q[$];
  logic po_q = 1'b0;
  int run_len = 0;

  clk_sync_pulse_tracker #(.CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .MISS_W(MISS_W)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .cfg_master_mode_i(master),
    .cfg_period_i(period), .cfg_window_i(window), .cfg_max_miss_i(max_miss),
    .tick_en_i(tick_en), .sync_pulse_i(sync_in), .clr_stats_i(clr),
    .sync_pulse_o(sync_out), .state_o(state), .curr_tick_o(curr_tick),
    .nb_sync_o(nb_sync), .nb_miss_o(nb_miss), .nb_reject_o(nb_reject),
    .last_offset_o(last_offset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle each output pulse starts and how long it stays high.
  always @(negedge clk) begin
    if (sync_out && !po_q) begin
      obs_q.push_back(cyc);
      run_len = 1;
    end else if (sync_out) begin
      run_len++;
    end else if (po_q) begin
      len_q.push_back(run_len);
    end
    po_q = sync_out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0; master = m; sync_in = 1'b0; clr = 1'b0; tick_en = 1'b1;
    period = 64'd10; window = 8'd2; max_miss = 4'd3;
    tick(2);
    rst_n = 1'b1;
    obs_q.delete(); len_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (sync_out !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0d exp=0", sync_out); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (curr_tick !== 64'd0) begin failures++; $display("FAIL reset_tick got=%0d exp=0", curr_tick); end
    checks++; if (nb_sync !== 64'd0 || nb_miss !== 32'd0 || nb_reject !== 32'd0 || last_offset !== 16'd0) begin
      failures++; $display("FAIL reset_stats got sync=%0d miss=%0d rej=%0d off=%0d exp all 0", nb_sync, nb_miss, nb_reject, last_offset);
    end
    rst_n = 1'b1;
    tick(3);
    checks++; if (curr_tick !== 64'd3) begin failures++; $display("FAIL reset_count_start got=%0d exp=3", curr_tick); end
  endtask

  task automatic test_master();
    int base, e, o;
    do_reset(1'b1);
    base = cyc;
    exp_q.push_back(base + 10); exp_q.push_back(base + 20); exp_q.push_back(base + 30);
    tick(15);
    sync_in = 1'b1;
    tick(2);
    sync_in = 1'b0;
    tick(13);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL master_state got=%0d exp=3", state); end
    checks++; if (nb_sync !== 64'd3) begin failures++; $display("FAIL master_nb_sync got=%0d exp=3", nb_sync); end
    checks++; if (nb_reject !== 32'd0) begin failures++; $display("FAIL master_ignores_input got=%0d exp=0", nb_reject); end
    tick(5);
    checks++; if (curr_tick !== 64'd5) begin failures++; $display("FAIL master_tick got=%0d exp=5", curr_tick); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL master_pulse_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL master_pulse_start got=%0d exp=%0d", o, e); end
    end
    while (len_q.size() > 0) begin
      o = len_q.pop_front();
      checks++; if (o !== PULSE_LEN) begin failures++; $display("FAIL master_pulse_len got=%0d exp=%0d", o, PULSE_LEN); end
    end
  endtask

  task automatic test_mode_clear();
    do_reset(1'b1);
    tick(3);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL mode_to_master got=%0d exp=3", state); end
    master = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0 || curr_tick !== 64'd4) begin
      failures++; $display("FAIL mode_to_slave got state=%0d tick=%0d exp state=0 tick=4", state, curr_tick);
    end
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    tick(3);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (nb_sync !== 64'd1 || nb_reject !== 32'd1) begin
      failures++; $display("FAIL clear_pre got sync=%0d rej=%0d exp sync=1 rej=1", nb_sync, nb_reject);
    end
    tick(4);
    sync_in = 1'b1; clr = 1'b1; tick(1); sync_in = 1'b0; clr = 1'b0;
    checks++; if (nb_sync !== 64'd0 || nb_reject !== 32'd0 || nb_miss !== 32'd0 || last_offset !== 16'd0) begin
      failures++; $display("FAIL clear_beats_accept got sync=%0d miss=%0d rej=%0d off=%0d exp all 0", nb_sync, nb_miss, nb_reject, last_offset);
    end
    checks++; if (state !== 2'd1 || curr_tick !== 64'd0) begin
      failures++; $display("FAIL clear_accept_realign got state=%0d tick=%0d exp state=1 tick=0", state, curr_tick);
    end
  endtask

  task automatic test_slave_lock();
    int e, o;
    do_reset(1'b0);
    tick(5);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (state !== 2'd1 || curr_tick !== 64'd0) begin
      failures++; $display("FAIL lock got state=%0d tick=%0d exp state=1 tick=0", state, curr_tick);
    end
    tick(8);
    exp_q.push_back(cyc + 1);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (last_offset !== 16'hfffe || curr_tick !== 64'd0) begin
      failures++; $display("FAIL late_offset got off=%0d tick=%0d exp off=-2 tick=0", $signed(last_offset), curr_tick);
    end
    tick(1);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (last_offset !== 16'd1) begin failures++; $display("FAIL early_offset got=%0d exp=1", $signed(last_offset)); end
    tick(5);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (nb_reject !== 32'd1 || nb_sync !== 64'd3) begin
      failures++; $display("FAIL reject got rej=%0d sync=%0d exp rej=1 sync=3", nb_reject, nb_sync);
    end
    checks++; if (curr_tick !== 64'd6 || state !== 2'd1) begin
      failures++; $display("FAIL reject_no_realign got tick=%0d state=%0d exp tick=6 state=1", curr_tick, state);
    end
    tick(1);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL lock_pulse_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL lock_pulse_start got=%0d exp=%0d", o, e); end
    end
  endtask

  task automatic test_holdover();
    int a, e, o;
    do_reset(1'b0);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    tick(1);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    a = cyc;
    exp_q.push_back(a + 10); exp_q.push_back(a + 20); exp_q.push_back(a + 30);
    tick(13);
    checks++; if (nb_miss !== 32'd1 || state !== 2'd1) begin
      failures++; $display("FAIL miss1 got miss=%0d state=%0d exp miss=1 state=1", nb_miss, state);
    end
    tick(10);
    checks++; if (nb_miss !== 32'd2 || state !== 2'd1) begin
      failures++; $display("FAIL miss2 got miss=%0d state=%0d exp miss=2 state=1", nb_miss, state);
    end
    tick(10);
    checks++; if (nb_miss !== 32'd3 || state !== 2'd2) begin
      failures++; $display("FAIL miss3_holdover got miss=%0d state=%0d exp miss=3 state=2", nb_miss, state);
    end
    tick(3);
    exp_q.push_back(cyc + 1);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (state !== 2'd1 || curr_tick !== 64'd0) begin
      failures++; $display("FAIL relock got state=%0d tick=%0d exp state=1 tick=0", state, curr_tick);
    end
    checks++; if (last_offset !== 16'd6 || nb_sync !== 64'd3) begin
      failures++; $display("FAIL relock_offset got off=%0d sync=%0d exp off=6 sync=3", $signed(last_offset), nb_sync);
    end
    tick(5);
    checks++; if (nb_miss !== 32'd3) begin failures++; $display("FAIL relock_miss got=%0d exp=3", nb_miss); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL hold_pulse_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL hold_pulse_start got=%0d exp=%0d", o, e); end
    end
  endtask

  task automatic test_period_change();
    do_reset(1'b0);
    tick(8);
    period = 64'd5;
    tick(1);
    checks++; if (curr_tick !== 64'd0) begin failures++; $display("FAIL period_shrink_wrap got=%0d exp=0", curr_tick); end
    window = 8'd7;
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    tick(3);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (last_offset !== 16'hfffe || curr_tick !== 64'd0) begin
      failures++; $display("FAIL clamped_late got off=%0d tick=%0d exp off=-2 tick=0", $signed(last_offset), curr_tick);
    end
    tick(2);
    sync_in = 1'b1; tick(1); sync_in = 1'b0;
    checks++; if (last_offset !== 16'd2 || nb_reject !== 32'd0 || nb_sync !== 64'd3) begin
      failures++; $display("FAIL clamped_early got off=%0d rej=%0d sync=%0d exp off=2 rej=0 sync=3", $signed(last_offset), nb_reject, nb_sync);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick(11);
    checks++; if (sync_out !== 1'b1) begin failures++; $display("FAIL stretch_active got=%0d exp=1", sync_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sync_out !== 1'b0) begin failures++; $display("FAIL async_pulse got=%0d exp=0", sync_out); end
    checks++; if (curr_tick !== 64'd0 || nb_sync !== 64'd0 || state !== 2'd0) begin
      failures++; $display("FAIL async_clear got tick=%0d sync=%0d state=%0d exp all 0", curr_tick, nb_sync, state);
    end
    master = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL post_reset_state got=%0d exp=0", state); end
  endtask

  initial begin
    test_reset();
    test_master();
    test_mode_clear();
    test_slave_lock();
    test_holdover();
    test_period_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
